// File: rtl/inst_encoder_if.sv
// Field-bundle handshake into the encoder and the stallable instruction-memory
// write port out of it.
interface enc_fields_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;

    modport master (
        output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm,
        output in_ready
    );
endinterface

interface enc_mem_if #(parameter int ADDR_WIDTH = 10);
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic                  mem_ack;

    modport master (
        output mem_we, mem_addr, mem_wdata,
        input  mem_ack
    );

    modport slave (
        input  mem_we, mem_addr, mem_wdata,
        output mem_ack
    );
endinterface

// File: rtl/inst_encoder.sv
// RV32I instruction encoder: validates and packs field bundles, then writes the
// resulting words sequentially into instruction memory.
module inst_encoder #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    enc_fields_if.slave         fields,
    enc_mem_if.master           mem,
    output logic [ADDR_WIDTH:0] count,
    output logic                full,
    output logic                err,
    output logic [1:0]          err_code
);

    typedef enum logic [1:0] {
        IDLE,
        ENCODE,
        WRITE,
        FULL
    } state_e;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_RANGE = 2'd1,
        ERR_ALIGN = 2'd2,
        ERR_FMT   = 2'd3
    } err_e;

    typedef struct packed {
        fmt_e        fmt;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } bundle_t;

    localparam logic [ADDR_WIDTH:0] CAPACITY = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_e                state_q, state_d;
    bundle_t               cap_q, cap_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  full_q, full_d;
    logic                  err_q, err_d;
    err_e                  code_q, code_d;

    err_e                  chk;
    logic [31:0]           packed_word;
    logic [ADDR_WIDTH:0]   count_inc;

    // Priority: illegal format, then misalignment, then out-of-range immediate.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        chk = ERR_NONE;
        case (cap_q.fmt)
            FMT_R: chk = ERR_NONE;
            FMT_I, FMT_S: begin
                if (cap_q.imm != {{20{cap_q.imm[11]}}, cap_q.imm[11:0]})
                    chk = ERR_RANGE;
            end
            FMT_B: begin
                if (cap_q.imm[0])
                    chk = ERR_ALIGN;
                else if (cap_q.imm != {{19{cap_q.imm[12]}}, cap_q.imm[12:0]})
                    chk = ERR_RANGE;
            end
            FMT_U: begin
                if (cap_q.imm[11:0] != 12'd0)
                    chk = ERR_RANGE;
            end
            FMT_J: begin
                if (cap_q.imm[0])
                    chk = ERR_ALIGN;
                else if (cap_q.imm != {{11{cap_q.imm[20]}}, cap_q.imm[20:0]})
                    chk = ERR_RANGE;
            end
            default: chk = ERR_FMT;
        endcase
    end

    always_comb begin
        packed_word = 32'd0;
        case (cap_q.fmt)
            FMT_R: packed_word = {cap_q.funct7, cap_q.rs2, cap_q.rs1, cap_q.funct3,
                                  cap_q.rd, cap_q.opcode};
            FMT_I: packed_word = {cap_q.imm[11:0], cap_q.rs1, cap_q.funct3,
                                  cap_q.rd, cap_q.opcode};
            FMT_S: packed_word = {cap_q.imm[11:5], cap_q.rs2, cap_q.rs1, cap_q.funct3,
                                  cap_q.imm[4:0], cap_q.opcode};
            FMT_B: packed_word = {cap_q.imm[12], cap_q.imm[10:5], cap_q.rs2, cap_q.rs1,
                                  cap_q.funct3, cap_q.imm[4:1], cap_q.imm[11], cap_q.opcode};
            FMT_U: packed_word = {cap_q.imm[31:12], cap_q.rd, cap_q.opcode};
            FMT_J: packed_word = {cap_q.imm[20], cap_q.imm[10:1], cap_q.imm[11],
                                  cap_q.imm[19:12], cap_q.rd, cap_q.opcode};
            default: packed_word = 32'd0;
        endcase
    end

    assign count_inc = count_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cap_d   = cap_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        count_d = count_q;
        full_d  = full_q;
        err_d   = err_q;
        code_d  = code_q;

        if (clr) begin
            // A clear in WRITE abandons the pending word without counting it.
            state_d = IDLE;
            we_d    = 1'b0;
            addr_d  = '0;
            count_d = '0;
            full_d  = 1'b0;
            err_d   = 1'b0;
            code_d  = ERR_NONE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fields.in_valid) begin
                        cap_d.fmt    = fmt_e'(fields.in_fmt);
                        cap_d.opcode = fields.in_opcode;
                        cap_d.rd     = fields.in_rd;
                        cap_d.rs1    = fields.in_rs1;
                        cap_d.rs2    = fields.in_rs2;
                        cap_d.funct3 = fields.in_funct3;
                        cap_d.funct7 = fields.in_funct7;
                        cap_d.imm    = fields.in_imm;
                        state_d      = ENCODE;
                    end
                end
                ENCODE: begin
                    if (chk != ERR_NONE) begin
                        err_d = 1'b1;
                        if (!err_q)
                            code_d = chk;
                        state_d = IDLE;
                    end else begin
                        wdata_d = packed_word;
                        we_d    = 1'b1;
                        state_d = WRITE;
                    end
                end
                WRITE: begin
                    if (mem.mem_ack) begin
                        we_d    = 1'b0;
                        addr_d  = addr_q + 1'b1;
                        count_d = count_inc;
                        if (count_inc == CAPACITY) begin
                            full_d  = 1'b1;
                            state_d = FULL;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                FULL: state_d = FULL;
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cap_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
        end else begin
            state_q <= state_d;
            cap_q   <= cap_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
            full_q  <= full_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    // Gating with rst_n keeps in_ready low for the whole reset pulse.
    assign fields.in_ready = (state_q == IDLE) && rst_n;

    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

    assign count    = count_q;
    assign full     = full_q;
    assign err      = err_q;
    assign err_code = code_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed scenarios followed by random
// field bundles compared against an arithmetic reference model.
module tb_inst_encoder;

    localparam int AW = 2;

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } fields_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clr = 1'b0;
    logic [AW:0]  count;
    logic         full;
    logic         err;
    logic [1:0]   err_code;

    enc_fields_if            fb ();
    enc_mem_if #(.ADDR_WIDTH(AW)) mb ();

    inst_encoder #(.ADDR_WIDTH(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .fields   (fb),
        .mem      (mb),
        .count    (count),
        .full     (full),
        .err      (err),
        .err_code (err_code)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference state
    int m_count = 0;
    int m_addr  = 0;
    bit m_full  = 0;
    bit m_err   = 0;
    int m_code  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int exp_code(input fields_t f);
        int s;
        s = $signed(f.imm);
        if (f.fmt > 3'd5) return 3;
        if ((f.fmt == 3'd3 || f.fmt == 3'd5) && (f.imm % 2 != 0)) return 2;
        case (f.fmt)
            3'd1, 3'd2: if (s < -2048 || s > 2047) return 1;
            3'd3:       if (s < -4096 || s > 4095) return 1;
            3'd5:       if (s < -(1 << 20) || s > (1 << 20) - 1) return 1;
            3'd4:       if (f.imm % 4096 != 0) return 1;
            default: ;
        endcase
        return 0;
    endfunction

    function automatic logic [31:0] exp_word(input fields_t f);
        bit [31:0] u, op, rd, rs1, rs2, f3, f7;
        u = f.imm; op = 32'(f.opcode); rd = 32'(f.rd); rs1 = 32'(f.rs1);
        rs2 = 32'(f.rs2); f3 = 32'(f.funct3); f7 = 32'(f.funct7);
        case (f.fmt)
            3'd0: return (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
            3'd1: return ((u & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
            3'd2: return (((u >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                       | ((u & 32'h1F) << 7) | op;
            3'd3: return (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | (rs2 << 20)
                       | (rs1 << 15) | (f3 << 12) | (((u >> 1) & 32'hF) << 8)
                       | (((u >> 11) & 1) << 7) | op;
            3'd4: return (u & 32'hFFFFF000) | (rd << 7) | op;
            3'd5: return (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21)
                       | (((u >> 11) & 1) << 20) | (((u >> 12) & 32'hFF) << 12) | (rd << 7) | op;
            default: return 32'd0;
        endcase
    endfunction

    function automatic fields_t mk(input int fmt, input int op, input int rd, input int rs1,
                                   input int rs2, input int f3, input int f7, input int imm);
        fields_t f;
        f.fmt = 3'(fmt); f.opcode = 7'(op); f.rd = 5'(rd); f.rs1 = 5'(rs1);
        f.rs2 = 5'(rs2); f.funct3 = 3'(f3); f.funct7 = 7'(f7); f.imm = 32'(imm);
        return f;
    endfunction

    // Present one bundle; returns on the negedge after the accept edge (DUT in ENCODE).
    task automatic send(input fields_t f);
        int waited = 0;
        while (fb.in_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (fb.in_ready !== 1'b1) begin
            total++; bad++;
            $error("FAIL ready_timeout: observed=%b expected=1", fb.in_ready);
        end
        fb.in_valid  = 1'b1;
        fb.in_fmt    = f.fmt;
        fb.in_opcode = f.opcode;
        fb.in_rd     = f.rd;
        fb.in_rs1    = f.rs1;
        fb.in_rs2    = f.rs2;
        fb.in_funct3 = f.funct3;
        fb.in_funct7 = f.funct7;
        fb.in_imm    = f.imm;
        @(negedge clk);
        fb.in_valid  = 1'b0;
        fb.in_imm    = $urandom;
    endtask

    task automatic txn(input fields_t f, input logic [31:0] want, input int delay);
        int code;
        code = exp_code(f);
        send(f);
        check("encode_ready", 32'(fb.in_ready), 32'd0);
        @(negedge clk);
        if (code != 0) begin
            if (!m_err) m_code = code;
            m_err = 1;
            check("err_no_we", 32'(mb.mem_we), 32'd0);
            check("err_flag", 32'(err), 32'(m_err));
            check("err_code", 32'(err_code), 32'(m_code));
            check("err_ready", 32'(fb.in_ready), 32'd1);
        end else begin
            check("we_high", 32'(mb.mem_we), 32'd1);
            check("wr_addr", 32'(mb.mem_addr), 32'(m_addr));
            check("wr_data", mb.mem_wdata, want);
            for (int i = 0; i < delay; i++) begin
                @(negedge clk);
                check("stall_we", 32'(mb.mem_we), 32'd1);
                check("stall_addr", 32'(mb.mem_addr), 32'(m_addr));
                check("stall_data", mb.mem_wdata, want);
                check("stall_ready", 32'(fb.in_ready), 32'd0);
                check("stall_count", 32'(count), 32'(m_count));
            end
            mb.mem_ack = 1'b1;
            @(negedge clk);
            mb.mem_ack = 1'b0;
            m_count++;
            m_addr = (m_addr + 1) % (1 << AW);
            if (m_count == (1 << AW)) m_full = 1;
            check("ack_we", 32'(mb.mem_we), 32'd0);
            check("ack_count", 32'(count), 32'(m_count));
            check("ack_addr", 32'(mb.mem_addr), 32'(m_addr));
            check("ack_full", 32'(full), 32'(m_full));
            check("ack_ready", 32'(fb.in_ready), 32'(!m_full));
        end
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        m_count = 0; m_addr = 0; m_full = 0; m_err = 0; m_code = 0;
        check("clr_count", 32'(count), 32'd0);
        check("clr_addr", 32'(mb.mem_addr), 32'd0);
        check("clr_full", 32'(full), 32'd0);
        check("clr_err", 32'(err), 32'd0);
        check("clr_code", 32'(err_code), 32'd0);
        check("clr_ready", 32'(fb.in_ready), 32'd1);
        check("clr_we", 32'(mb.mem_we), 32'd0);
    endtask

    function automatic int rand_imm();
        int bnd[10] = '{2047, -2048, 2048, -2049, 4094, -4096, 4096, 1048574, -1048576, 1048576};
        case ($urandom_range(0, 5))
            0: return int'($urandom_range(0, 4095)) - 2048;
            1: return bnd[$urandom_range(0, 9)];
            2: return int'($urandom);
            3: return int'($urandom & 32'hFFFFF000);
            4: return int'($urandom_range(0, 8191)) - 4096;
            default: return int'($urandom_range(0, (1 << 21) - 1)) - (1 << 20);
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        fields_t f;
        fb.in_valid = 1'b0; fb.in_fmt = '0; fb.in_opcode = '0; fb.in_rd = '0;
        fb.in_rs1 = '0; fb.in_rs2 = '0; fb.in_funct3 = '0; fb.in_funct7 = '0; fb.in_imm = '0;
        mb.mem_ack = 1'b0;

        // Reset state
        #12;
        check("rst_ready", 32'(fb.in_ready), 32'd0);
        check("rst_we", 32'(mb.mem_we), 32'd0);
        check("rst_wdata", mb.mem_wdata, 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(fb.in_ready), 32'd1);

        // Directed encodings
        txn(mk(1, 'h13, 1, 0, 0, 0, 0, 5), 32'h00500093, 0);
        txn(mk(5, 'h6F, 1, 0, 0, 0, 0, 'h800), 32'h001000EF, 0);
        txn(mk(2, 'h23, 0, 1, 2, 2, 0, -4), 32'hFE20AE23, 0);

        // First error sticks: misaligned B, then out-of-range I
        txn(mk(3, 'h63, 0, 1, 2, 0, 0, 3), 32'd0, 0);
        txn(mk(1, 'h13, 1, 0, 0, 0, 0, 2048), 32'd0, 0);
        check("sticky_code", 32'(err_code), 32'd2);
        do_clr();

        // Stalled acknowledge
        f = mk(0, 'h33, 3, 4, 5, 0, 'h20, 0);
        txn(f, exp_word(f), 4);

        // Fill the memory, then try once more
        do_clr();
        for (int i = 0; i < 4; i++) begin
            f = mk(4, 'h37, i + 1, 0, 0, 0, 0, (i + 1) << 12);
            txn(f, exp_word(f), i % 2);
        end
        check("full_flag", 32'(full), 32'd1);
        check("full_wrap", 32'(mb.mem_addr), 32'd0);
        fb.in_valid = 1'b1;
        fb.in_fmt   = 3'd1;
        fb.in_imm   = 32'd1;
        repeat (3) @(negedge clk);
        fb.in_valid = 1'b0;
        check("full_no_we", 32'(mb.mem_we), 32'd0);
        check("full_count", 32'(count), 32'd4);
        check("full_ready", 32'(fb.in_ready), 32'd0);
        do_clr();

        // Clear while a write is pending
        f = mk(1, 'h13, 2, 3, 0, 1, 0, -1);
        send(f);
        @(negedge clk);
        check("pre_clr_we", 32'(mb.mem_we), 32'd1);
        do_clr();

        // Reset while a write is pending
        f = mk(1, 'h13, 2, 3, 0, 1, 0, 100);
        send(f);
        @(negedge clk);
        check("pre_rst_we", 32'(mb.mem_we), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_we", 32'(mb.mem_we), 32'd0);
        check("async_ready", 32'(fb.in_ready), 32'd0);
        check("async_wdata", mb.mem_wdata, 32'd0);
        check("async_addr", 32'(mb.mem_addr), 32'd0);
        m_count = 0; m_addr = 0; m_full = 0; m_err = 0; m_code = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rerst_ready", 32'(fb.in_ready), 32'd1);

        // Random bundles against the reference model
        for (int n = 0; n < 60; n++) begin
            if (m_full || $urandom_range(0, 15) == 0) do_clr();
            f = mk($urandom_range(0, 7), $urandom_range(0, 127), $urandom_range(0, 31),
                   $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 7),
                   $urandom_range(0, 127), rand_imm());
            txn(f, exp_word(f), $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Inverse of the processor's immediate decode path. Accepts instruction fields (format, opcode, registers, functs, 32-bit immediate) over a valid/ready handshake and validates the immediate against the format's range and alignment. It packs legal instructions into 32-bit RV32I words and writes them sequentially into instruction memory through a stallable write port. It is used by the boot/debug loader to build programs in instruction memory.

## Interface

- ADDR_WIDTH, 10, word-address width of instruction memory; capacity 2^ADDR_WIDTH words.
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous clear: address, count, full, err, err_code to 0, FSM to IDLE.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  high only in IDLE while rst_n high.
- in_fmt  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6/7 illegal.
- in_opcode  in  7; in_rd  in  5; in_rs1  in  5; in_rs2  in  5; in_funct3  in  3; in_funct7  in  7  instruction fields; fields unused by the format are ignored.
- in_imm  in  32  byte-offset immediate, two's complement (U: full 32-bit value).
- mem_we  out  1  write request, held until acknowledged.
- mem_addr  out  ADDR_WIDTH  word address.
- mem_wdata  out  32  encoded instruction.
- mem_ack  in  1  write accepted on this edge when mem_we=1.
- count  out  ADDR_WIDTH+1  instructions written since reset/clr.
- full  out  1  memory filled.
- err  out  1  sticky error flag.
- err_code  out  2  first error since reset/clr: 1=range, 2=misaligned, 3=illegal format.

## Operation

- FSM states: IDLE, ENCODE, WRITE, FULL.
- IDLE: in_ready=1. When in_valid is high, all inputs are captured and the FSM goes to ENCODE.
- ENCODE, one cycle: check and pack. Check priority: format > alignment > range.
  - Range rules: I/S need in_imm to equal sign-extended in_imm[11:0]. B needs sign-extended [12:0]. J needs sign-extended [20:0]. U needs in_imm[11:0]==0; violating U is a range error.
  - Alignment rule: B/J need in_imm[0]==0.
  - On error: set err; set err_code only if err was 0; no write; go to IDLE.
  - On success: register mem_wdata; set mem_we=1; go to WRITE.
- Packing rules:
  - R: {funct7, rs2, rs1, funct3, rd, opcode}.
  - I: {imm[11:0], rs1, funct3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - U: {imm[31:12], rd, opcode}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
- WRITE: mem_we, mem_addr and mem_wdata are held stable until mem_ack. On the ack edge:
  - mem_we goes to 0; mem_addr increments, wrapping to 0; count increments.
  - If the new count equals 2^ADDR_WIDTH: full=1 and go to FULL. Otherwise go to IDLE.
- FULL: in_ready=0 and no writes. Only clr or reset exits.
- clr has priority over everything, in any state. A clr during WRITE aborts the write: mem_we is 0 next cycle, count is unchanged.
- Reset values: FSM IDLE, mem_we 0, mem_addr 0, mem_wdata 0, count 0, full 0, err 0, err_code 0, in_ready 0 while rst_n low.
- Reset asserted mid-WRITE drops mem_we immediately (asynchronously).

## Timing

- Accept edge (T0) -> ENCODE at T1 -> mem_we high from T2.
- Minimum 3 cycles per instruction (ack at T2 edge); in_ready high again at T3.
- Error path: the err flag is visible after T1 and in_ready is high at T2.
- in_ready is low throughout ENCODE, WRITE and FULL. in_valid in those states is ignored, not queued.
- count, mem_addr and full update on the same edge as the accepted mem_ack.

## Test plan

- fmt I, opcode 0x13, rd 1, rs1 0, funct3 0, imm 5 -> mem_wdata 0x00500093 at mem_addr 0; count=1 after ack.
- fmt S, opcode 0x23, rs1 1, rs2 2, funct3 2, imm -4 -> 0xFE20AE23; fmt J, opcode 0x6F, rd 1, imm 0x800 -> 0x001000EF at mem_addr 1.
- fmt B imm 3 -> no mem_we, err=1, err_code=2; then fmt I imm 2048 -> err_code still 2; clr -> err=0, err_code=0, count=0.
- mem_ack held low 4 cycles in WRITE -> mem_we, mem_addr and mem_wdata stable, in_ready=0; ack -> count increments once.
- ADDR_WIDTH=2, four legal writes -> full=1 and in_ready=0 on the 4th ack, mem_addr wrapped to 0; fifth in_valid ignored; clr -> full=0, in_ready=1.
- rst_n pulsed low during WRITE -> mem_we=0 immediately, all outputs at reset values; rst_n released -> in_ready=1.
